// File: rtl/decode_issue_queue_pkg.sv
// decode_issue_queue_pkg: shared widths, decode flag positions and the instruction decode helper
package decode_issue_queue_pkg;
    localparam int WORD   = 32;
    localparam int ADDR   = 32;
    localparam int W_RD   = 5;
    localparam int W_IMM  = 16;
    localparam int W_OPC  = WORD - 1 - 2 * W_RD - W_IMM;
    localparam int D_INFO = 3;
    localparam int F_WEN  = 0;
    localparam int F_SEXT = 1;
    localparam int F_IMM  = 2;

    // Flags are the low bits of the field that starts just above r0.
    function automatic logic [D_INFO-1:0] decode_inst(input logic [WORD-1:0] inst);
        return inst[2*W_RD+W_IMM +: D_INFO];
    endfunction
endpackage

// File: rtl/decode_issue_queue_if.sv
// decode_issue_queue_if: fetch, regfile, writeback and execute-bundle signals of the decode stage
interface decode_issue_queue_if;
    import decode_issue_queue_pkg::*;
    logic             v_i;
    logic             rdy_o;
    logic [WORD-1:0]  inst_i;
    logic [ADDR-1:0]  pc_i;
    logic             branch_i;
    logic [W_RD-1:0]  r0_o;
    logic [W_RD-1:0]  r1_o;
    logic [WORD-1:0]  r_opr0_i;
    logic [WORD-1:0]  r_opr1_i;
    logic             wb_v_i;
    logic [W_RD-1:0]  wb_r_i;
    logic             stall_i;
    logic             v_o;
    logic [W_OPC-1:0] opecode_o;
    logic [WORD-1:0]  opr0_o;
    logic [WORD-1:0]  opr1_o;
    logic [WORD-1:0]  imm_o;
    logic [W_RD-1:0]  wb_r_o;
    logic [ADDR-1:0]  pc_o;

    modport slave (
        input  v_i, inst_i, pc_i, branch_i, r_opr0_i, r_opr1_i, wb_v_i, wb_r_i, stall_i,
        output rdy_o, r0_o, r1_o, v_o, opecode_o, opr0_o, opr1_o, imm_o, wb_r_o, pc_o
    );
    modport master (
        output v_i, inst_i, pc_i, branch_i, r_opr0_i, r_opr1_i, wb_v_i, wb_r_i, stall_i,
        input  rdy_o, r0_o, r1_o, v_o, opecode_o, opr0_o, opr1_o, imm_o, wb_r_o, pc_o
    );
endinterface

// File: rtl/decode_issue_queue_fifo.sv
// decode_inst_fifo: circular WIDTH x DEPTH queue with flush and combinational head read
module decode_inst_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int W = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [W-1:0] wp, rp;
    logic [W:0] cnt;
    logic do_push, do_pop;

    assign full    = cnt == (W+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign dout    = mem[rp];
    // A full queue refuses the push even when the head leaves in the same cycle.
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            cnt <= cnt + {{W{1'b0}}, do_push} - {{W{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/decode_issue_queue.sv
// decode_issue_queue: queued decode stage with an internal register scoreboard and a registered issue bundle
module decode_issue_queue
    import decode_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic               clk,
    input logic               reset,
    decode_issue_queue_if.slave bus
);
    logic [WORD+ADDR-1:0] head;
    logic                 q_empty, q_full, push, issue, hz, load;
    logic [WORD-1:0]      h_inst, h_ext;
    logic [ADDR-1:0]      h_pc;
    logic [D_INFO-1:0]    h_info;
    logic [W_RD-1:0]      h_r0, h_r1;
    logic [2**W_RD-1:0]   busy, busy_d;
    logic                 v_q, wen_q;
    logic [W_OPC-1:0]     opc_q;
    logic [WORD-1:0]      opr0_q, opr1_q, imm_q;
    logic [W_RD-1:0]      wb_r_q;
    logic [ADDR-1:0]      pc_q;

    decode_inst_fifo #(.WIDTH(WORD + ADDR), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (bus.branch_i),
        .push  (push),
        .pop   (issue),
        .din   ({bus.inst_i, bus.pc_i}),
        .dout  (head),
        .full  (q_full),
        .empty (q_empty)
    );

    assign {h_inst, h_pc} = head;
    assign h_info = decode_inst(h_inst);
    assign h_r0   = h_inst[2*W_RD+W_IMM-1 -: W_RD];
    assign h_r1   = h_inst[W_RD+W_IMM-1 -: W_RD];
    assign h_ext  = h_info[F_SEXT] ? {{(WORD-W_IMM){h_inst[W_IMM-1]}}, h_inst[W_IMM-1:0]}
                                   : {{(WORD-W_IMM){1'b0}}, h_inst[W_IMM-1:0]};

    assign push  = bus.v_i & ~q_full;
    assign hz    = busy[h_r0] | (~h_info[F_IMM] & busy[h_r1]);
    assign load  = ~v_q | ~bus.stall_i;
    assign issue = ~q_empty & ~hz & load & ~bus.branch_i;

    // Clear before set so an issuing writer keeps its register reserved.
    always_comb begin
        busy_d = busy;
        if (bus.wb_v_i) busy_d[bus.wb_r_i] = 1'b0;
        if (bus.branch_i & v_q & wen_q) busy_d[wb_r_q] = 1'b0;
        if (issue & h_info[F_WEN]) busy_d[h_r0] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy   <= '0;
            v_q    <= 1'b0;
            wen_q  <= 1'b0;
            opc_q  <= '0;
            opr0_q <= '0;
            opr1_q <= '0;
            imm_q  <= '0;
            wb_r_q <= '0;
            pc_q   <= '0;
        end else begin
            busy <= busy_d;
            if (bus.branch_i) v_q <= 1'b0;
            else if (issue) begin
                v_q    <= 1'b1;
                wen_q  <= h_info[F_WEN];
                opc_q  <= h_inst[WORD-1 -: W_OPC];
                opr0_q <= bus.r_opr0_i;
                opr1_q <= h_info[F_IMM] ? h_ext : bus.r_opr1_i;
                imm_q  <= h_ext;
                wb_r_q <= h_r0;
                pc_q   <= h_pc;
            end else if (load) v_q <= 1'b0;
        end
    end

    assign bus.rdy_o     = ~q_full;
    assign bus.r0_o      = q_empty ? '0 : h_r0;
    assign bus.r1_o      = q_empty ? '0 : h_r1;
    assign bus.v_o       = v_q;
    assign bus.opecode_o = opc_q;
    assign bus.opr0_o    = opr0_q;
    assign bus.opr1_o    = opr1_q;
    assign bus.imm_o     = imm_q;
    assign bus.wb_r_o    = wb_r_q;
    assign bus.pc_o      = pc_q;
endmodule

// File: tb/tb_decode_issue_queue.sv
// tb_decode_issue_queue: directed scenarios plus random traffic checked against a queue-based reference model
module tb_decode_issue_queue;
    import decode_issue_queue_pkg::*;
    localparam int DEPTH = 4;

    typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    decode_issue_queue_if bus();
    decode_issue_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [31:0] rf [32];
    logic [31:0] wb_data;
    assign bus.r_opr0_i = rf[bus.r0_o];
    assign bus.r_opr1_i = rf[bus.r1_o];

    int n_cmp = 0;
    int n_bad = 0;

    ent_t        q[$];
    bit   [31:0] mb;
    bit          m_v, m_wen;
    logic [4:0]  m_opc, m_wbr;
    logic [31:0] m_opr0, m_opr1, m_imm, m_pc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int flags, input int r0, input int r1, input int imm);
        return 32'((flags << 26) | (r0 << 21) | (r1 << 16) | (imm & 'hFFFF));
    endfunction

    task automatic model_reset();
        q.delete();
        mb = '0;
        m_v = 0; m_wen = 0; m_opc = '0; m_wbr = '0;
        m_opr0 = '0; m_opr1 = '0; m_imm = '0; m_pc = '0;
    endtask

    task automatic model_edge();
        logic [31:0] hi, ext;
        bit wen, sx, ui, iss, pushed;
        bit [31:0] nb;
        int r0, r1;
        ent_t e;
        iss = 0; wen = 0; r0 = 0; r1 = 0; hi = '0; ext = '0; ui = 0;
        if (q.size() > 0) begin
            hi  = q[0].inst;
            r0  = int'((hi >> 21) & 31);
            r1  = int'((hi >> 16) & 31);
            wen = hi[26]; sx = hi[27]; ui = hi[28];
            ext = sx ? 32'($signed(hi[15:0])) : {16'h0, hi[15:0]};
            iss = !(mb[r0] || (!ui && mb[r1])) && (!m_v || !bus.stall_i) && !bus.branch_i;
        end
        nb = mb;
        if (bus.wb_v_i) nb[bus.wb_r_i] = 0;
        if (bus.branch_i && m_v && m_wen) nb[m_wbr] = 0;
        if (iss && wen) nb[r0] = 1;
        pushed = bus.v_i && q.size() < DEPTH;
        if (bus.branch_i) begin
            q.delete();
            m_v = 0;
        end else begin
            if (iss) begin
                e = q.pop_front();
                m_v = 1; m_wen = wen; m_opc = hi[31:27]; m_wbr = 5'(r0); m_pc = e.pc;
                m_opr0 = rf[r0]; m_opr1 = ui ? ext : rf[r1]; m_imm = ext;
            end else if (!m_v || !bus.stall_i) m_v = 0;
            if (pushed) q.push_back('{bus.inst_i, bus.pc_i});
        end
        mb = nb;
        if (bus.wb_v_i) rf[bus.wb_r_i] = wb_data;
    endtask

    task automatic compare();
        chk("v_o", bus.v_o, m_v);
        chk("rdy_o", bus.rdy_o, q.size() != DEPTH);
        if (q.size() > 0) begin
            chk("r0_o", bus.r0_o, (q[0].inst >> 21) & 31);
            chk("r1_o", bus.r1_o, (q[0].inst >> 16) & 31);
        end
        if (m_v) begin
            chk("pc_o", bus.pc_o, m_pc);
            chk("opecode_o", bus.opecode_o, m_opc);
            chk("opr0_o", bus.opr0_o, m_opr0);
            chk("opr1_o", bus.opr1_o, m_opr1);
            chk("imm_o", bus.imm_o, m_imm);
            chk("wb_r_o", bus.wb_r_o, m_wbr);
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic idle();
        bus.v_i = 0; bus.branch_i = 0; bus.wb_v_i = 0; bus.stall_i = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_v_o"}, bus.v_o, 0);
        chk({tag, "_rdy_o"}, bus.rdy_o, 1);
        chk({tag, "_pc_o"}, bus.pc_o, 0);
        chk({tag, "_wb_r_o"}, bus.wb_r_o, 0);
        chk({tag, "_opr1_o"}, bus.opr1_o, 0);
        chk({tag, "_imm_o"}, bus.imm_o, 0);
    endtask

    task automatic async_reset();
        idle();
        #1 reset = 0;
        #1 check_reset_outputs("async_rst");
        model_reset();
        #1 reset = 1;
    endtask

    initial begin
        int cnt;
        logic [31:0] seen[$];
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        wb_data = '0; bus.inst_i = '0; bus.pc_i = '0; bus.wb_r_i = '0;
        idle();
        model_reset();
        #2 check_reset_outputs("rst");
        @(posedge clk);
        #1 reset = 1;

        // ADDI r1, r0, #-1 with sign extension
        bus.v_i = 1; bus.inst_i = mk(7, 1, 0, 'hFFFF); bus.pc_i = 32'h100;
        step();
        bus.v_i = 0;
        step();
        chk("addi_v", bus.v_o, 1);
        chk("addi_opr1", bus.opr1_o, 32'hFFFF_FFFF);
        chk("addi_wb_r", bus.wb_r_o, 1);

        // ADD r2, r1 waits on r1 until writeback
        bus.v_i = 1; bus.inst_i = mk(1, 2, 1, 0); bus.pc_i = 32'h104;
        step();
        bus.v_i = 0;
        step(); step();
        chk("raw_block", bus.v_o, 0);
        bus.wb_v_i = 1; bus.wb_r_i = 1; wb_data = 32'h1234;
        step();
        bus.wb_v_i = 0;
        chk("raw_wb_edge", bus.v_o, 0);
        step();
        chk("raw_issue_v", bus.v_o, 1);
        chk("raw_issue_opr1", bus.opr1_o, 32'h1234);

        // stalled bundle, queue fills and rejects the fifth push
        bus.stall_i = 1;
        for (int i = 0; i < 5; i++) begin
            bus.v_i = 1; bus.inst_i = mk(4, 5, 6, i); bus.pc_i = 32'h200 + 32'(4 * i);
            step();
            chk("stall_hold_pc", bus.pc_o, 32'h104);
            if (i >= 3) chk("full_rdy", bus.rdy_o, 0);
        end
        bus.v_i = 0; bus.stall_i = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.v_o) seen.push_back(bus.pc_o);
        end
        chk("drain_cnt", seen.size(), 4);
        for (int i = 0; i < 4 && i < seen.size(); i++) chk("drain_pc", seen[i], 32'h200 + 32'(4 * i));

        // flush kills a writing bundle and three queued entries
        bus.stall_i = 1;
        for (int i = 0; i < 4; i++) begin
            bus.v_i = 1; bus.inst_i = i == 0 ? mk(5, 7, 0, 9) : mk(4, 5, 6, i); bus.pc_i = 32'h300 + 32'(4 * i);
            step();
        end
        bus.branch_i = 1; bus.inst_i = mk(4, 5, 6, 0); bus.pc_i = 32'h3F0;
        step();
        bus.branch_i = 0; bus.v_i = 0; bus.stall_i = 0;
        chk("flush_v", bus.v_o, 0);
        chk("flush_rdy", bus.rdy_o, 1);
        step();
        chk("flush_drop", bus.v_o, 0);
        bus.v_i = 1; bus.inst_i = mk(1, 8, 7, 0); bus.pc_i = 32'h310;
        step();
        bus.v_i = 0;
        step();
        chk("flush_free_v", bus.v_o, 1);
        chk("flush_free_pc", bus.pc_o, 32'h310);

        // back-to-back issue across pointer wrap
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            bus.v_i = i < 10; bus.inst_i = mk(4, 10, 11, i); bus.pc_i = 32'h400 + 32'(4 * i);
            step();
            if (bus.v_o) cnt++;
        end
        chk("wrap_cnt", cnt, 10);

        // set and clear of r3 in the same edge: set wins
        bus.v_i = 1; bus.inst_i = mk(5, 3, 0, 1); bus.pc_i = 32'h500;
        step();
        bus.v_i = 0; bus.wb_v_i = 1; bus.wb_r_i = 3; wb_data = 32'hABCD;
        step();
        bus.wb_v_i = 0;
        bus.v_i = 1; bus.inst_i = mk(1, 4, 3, 0); bus.pc_i = 32'h504;
        step();
        bus.v_i = 0;
        step(); step();
        chk("setclr_block", bus.v_o, 0);
        async_reset();
        bus.v_i = 1;
        step();
        bus.v_i = 0;
        step();
        chk("post_rst_v", bus.v_o, 1);
        chk("post_rst_wb_r", bus.wb_r_o, 4);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            logic [31:0] ins;
            if (c == 300) async_reset();
            ins = $urandom;
            ins[25:21] = 5'($urandom_range(0, 7));
            ins[20:16] = 5'($urandom_range(0, 7));
            bus.v_i = $urandom_range(0, 9) < 7;
            bus.inst_i = ins;
            bus.pc_i = 32'h1000 + 32'(4 * c);
            bus.stall_i = $urandom_range(0, 3) == 0;
            bus.branch_i = $urandom_range(0, 24) == 0;
            wb_data = $urandom;
            bus.wb_v_i = 0;
            if (mb != 0 && $urandom_range(0, 2) == 0) begin
                int r;
                r = $urandom_range(0, 31);
                while (!mb[r]) r = (r + 1) % 32;
                bus.wb_v_i = 1; bus.wb_r_i = 5'(r);
            end
            step();
        end
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
